// File: rtl/counter_cascade_ctrl.sv
// Run-to-target controller for a cascade of mod-RADIX counter stages with START/BUSY/DONE/ACK handshake.
// Optional build macro COUNTER_CASCADE_CTRL_PRESCALE_EN replaces TICK with an internal divide-by-PRESCALE tick.
`timescale 1ns/1ps
module counter_cascade_ctrl #(
    parameter int DIGITS   = 2,
    parameter int RADIX    = 20,
    parameter int WIDTH    = 5,
    parameter int PRESCALE = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [DIGITS*WIDTH-1:0] TGT,
    input  logic                    TICK,
    input  logic                    HOLD,
    input  logic                    ABORT,
    input  logic                    ACK,
    input  logic [DIGITS*WIDTH-1:0] CNT_STG,
    input  logic [DIGITS-1:0]       COUT_STG,
    output logic [DIGITS-1:0]       EN_STG,
    output logic                    CLR_STG,
    output logic                    BUSY,
    output logic                    DONE,
    output logic                    ERR,
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [WIDTH:0] RADIX_W = RADIX[WIDTH:0];

    state_t                  state;
    logic [DIGITS*WIDTH-1:0] tgt_q;
    logic                    tgt_ok;
    logic                    match;
    logic                    tick_src;
    logic                    run_tick;
    logic                    chain;

    // {CLR_STG, BUSY, DONE} as seen while sitting in state s
    function automatic logic [2:0] outs(input state_t s);
        return {s != S_CLEAR, (s == S_CLEAR) || (s == S_RUN) || (s == S_PAUSE), s == S_DONE};
    endfunction

    always_comb begin
        tgt_ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ({1'b0, TGT[i*WIDTH +: WIDTH]} >= RADIX_W) tgt_ok = 1'b0;
        end
    end

`ifdef COUNTER_CASCADE_CTRL_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic          unused_tick;

    assign unused_tick = TICK;

    // Frozen whenever HOLD is high so a pause resumes mid-period.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pre_q <= '0;
        end else if (state == S_CLEAR) begin
            pre_q <= '0;
        end else if (state == S_RUN && !HOLD) begin
            pre_q <= (pre_q == PS_LAST) ? '0 : pre_q + 1'b1;
        end
    end

    assign tick_src = (pre_q == PS_LAST);
`else
    logic unused_prescale;

    assign unused_prescale = ^PRESCALE;
    assign tick_src        = TICK;
`endif

    assign match    = (CNT_STG == tgt_q);
    assign run_tick = (state == S_RUN) & tick_src & ~HOLD & ~match;

    // Stage i advances only when every lower stage is at its terminal count.
    always_comb begin
        EN_STG = '0;
        chain  = run_tick;
        for (int i = 0; i < DIGITS; i++) begin
            EN_STG[i] = chain;
            chain     = chain & COUT_STG[i];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state                 <= S_IDLE;
            tgt_q                 <= '0;
            {CLR_STG, BUSY, DONE} <= 3'b100;
            ERR                   <= 1'b0;
        end else begin
            ERR <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START && tgt_ok) begin
                        tgt_q                 <= TGT;
                        state                 <= S_CLEAR;
                        {CLR_STG, BUSY, DONE} <= outs(S_CLEAR);
                    end else if (START) begin
                        ERR <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state                 <= S_RUN;
                    {CLR_STG, BUSY, DONE} <= outs(S_RUN);
                end
                S_RUN: begin
                    if (ABORT) begin
                        state                 <= S_IDLE;
                        {CLR_STG, BUSY, DONE} <= outs(S_IDLE);
                    end else if (match) begin
                        state                 <= S_DONE;
                        {CLR_STG, BUSY, DONE} <= outs(S_DONE);
                    end else if (HOLD) begin
                        state                 <= S_PAUSE;
                        {CLR_STG, BUSY, DONE} <= outs(S_PAUSE);
                    end
                end
                S_PAUSE: begin
                    if (ABORT) begin
                        state                 <= S_IDLE;
                        {CLR_STG, BUSY, DONE} <= outs(S_IDLE);
                    end else if (!HOLD) begin
                        state                 <= S_RUN;
                        {CLR_STG, BUSY, DONE} <= outs(S_RUN);
                    end
                end
                S_DONE: begin
                    // A valid START here doubles as the acknowledge for the finished run.
                    if (START && tgt_ok) begin
                        tgt_q                 <= TGT;
                        state                 <= S_CLEAR;
                        {CLR_STG, BUSY, DONE} <= outs(S_CLEAR);
                    end else if (ACK || ABORT) begin
                        state                 <= S_IDLE;
                        {CLR_STG, BUSY, DONE} <= outs(S_IDLE);
                    end
                    if (START && !tgt_ok) ERR <= 1'b1;
                end
                default: begin
                    state                 <= S_IDLE;
                    {CLR_STG, BUSY, DONE} <= outs(S_IDLE);
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_counter_cascade_ctrl.sv
// Directed bench for counter_cascade_ctrl driving a behavioural two-stage mod-20 cascade.
`timescale 1ns/1ps
module tb_counter_cascade_ctrl;

    localparam int BOUND = 3000;

    logic       CLK   = 1'b0;
    logic       RST   = 1'b0;
    logic       START = 1'b0;
    logic       TICK  = 1'b0;
    logic       HOLD  = 1'b0;
    logic       ABORT = 1'b0;
    logic       ACK   = 1'b0;
    logic [9:0] TGT   = '0;
    logic [9:0] stg   = '0;
    logic [1:0] cout;
    logic [1:0] EN_STG;
    logic       CLR_STG, BUSY, DONE, ERR;
    logic [2:0] dbg_state;

    int n_cmp = 0, n_err = 0;
    int en0_cnt = 0, en1_cnt = 0, clr_cnt = 0, done_cnt = 0, carry_bad = 0;
    int b0, b1, bc, bd;

    always #5 CLK = ~CLK;

    counter_cascade_ctrl #(.DIGITS(2), .RADIX(20), .WIDTH(5), .PRESCALE(4)) dut (
        .CLK(CLK), .RST(RST), .START(START), .TGT(TGT), .TICK(TICK), .HOLD(HOLD),
        .ABORT(ABORT), .ACK(ACK), .CNT_STG(stg), .COUT_STG(cout), .EN_STG(EN_STG),
        .CLR_STG(CLR_STG), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .dbg_state(dbg_state)
    );

    // Behavioural counter stages: synchronous active-low clear, mod-20 increment.
    assign cout[0] = (stg[4:0] == 5'd19);
    assign cout[1] = (stg[9:5] == 5'd19);

    always @(posedge CLK) begin
        if (!CLR_STG) begin
            stg <= '0;
        end else begin
            if (EN_STG[0]) stg[4:0] <= (stg[4:0] == 5'd19) ? 5'd0 : stg[4:0] + 5'd1;
            if (EN_STG[1]) stg[9:5] <= (stg[9:5] == 5'd19) ? 5'd0 : stg[9:5] + 5'd1;
        end
    end

    always @(negedge CLK) begin
        if (EN_STG[0]) en0_cnt++;
        if (EN_STG[1]) en1_cnt++;
        if (EN_STG[1] && stg[4:0] != 5'd19) carry_bad++;
        if (!CLR_STG) clr_cnt++;
        if (DONE) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic slot();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start(input logic [9:0] t);
        TGT   = t;
        START = 1'b1;
        slot();
        START = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int k = 0;
        while (!DONE && k < bound) begin
            slot();
            k++;
        end
        check(tag, {31'd0, DONE}, 32'd1);
    endtask

    task automatic wait_cnt(input string tag, input logic [9:0] v, input int bound);
        int k = 0;
        while (stg !== v && k < bound) begin
            slot();
            k++;
        end
        check(tag, {22'd0, stg}, {22'd0, v});
    endtask

    task automatic ack_done(input string tag);
        ACK = 1'b1;
        slot();
        ACK = 1'b0;
        check(tag, {29'd0, dbg_state}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) slot();
        check("rst_busy", {31'd0, BUSY}, 32'd0);
        check("rst_done", {31'd0, DONE}, 32'd0);
        check("rst_clr", {31'd0, CLR_STG}, 32'd1);
        check("rst_err", {31'd0, ERR}, 32'd0);
        check("rst_en", {30'd0, EN_STG}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, 32'd0);
        RST = 1'b1;
        slot();
        TICK = 1'b1;

        // Target 23 = {1,3}
        b0 = en0_cnt; b1 = en1_cnt; bc = clr_cnt;
        pulse_start({5'd1, 5'd3});
        check("basic_clr_low", {31'd0, CLR_STG}, 32'd0);
        check("basic_busy", {31'd0, BUSY}, 32'd1);
        check("basic_state_clear", {29'd0, dbg_state}, 32'd1);
        slot();
        check("basic_state_run", {29'd0, dbg_state}, 32'd2);
        check("basic_clr_high", {31'd0, CLR_STG}, 32'd1);
        wait_done("basic_done", BOUND);
        check("basic_en0", en0_cnt - b0, 32'd23);
        check("basic_en1", en1_cnt - b1, 32'd1);
        check("basic_clr_cycles", clr_cnt - bc, 32'd1);
        check("basic_cnt", {22'd0, stg}, {22'd0, 5'd1, 5'd3});
        check("basic_busy_done", {31'd0, BUSY}, 32'd0);
        ack_done("basic_ack");
        check("basic_done_drop", {31'd0, DONE}, 32'd0);

        // Target 0: done without any enable
        b0 = en0_cnt;
        pulse_start(10'd0);
        slot();
        wait_done("zero_done", 5);
        check("zero_en0", en0_cnt - b0, 32'd0);
        check("zero_cnt", {22'd0, stg}, 32'd0);
        ack_done("zero_ack");

        // Target {19,19} = 399
        b0 = en0_cnt; b1 = en1_cnt;
        pulse_start({5'd19, 5'd19});
        wait_done("max_done", BOUND);
        check("max_en0", en0_cnt - b0, 32'd399);
        check("max_en1", en1_cnt - b1, 32'd19);
        check("max_cnt", {22'd0, stg}, {22'd0, 5'd19, 5'd19});
        repeat (5) slot();
        check("max_nowrap", {22'd0, stg}, {22'd0, 5'd19, 5'd19});
        check("max_done_hold", {31'd0, DONE}, 32'd1);
        ack_done("max_ack");

        // Out-of-range digits
        pulse_start({5'd0, 5'd20});
        check("err_lo_pulse", {31'd0, ERR}, 32'd1);
        check("err_lo_busy", {31'd0, BUSY}, 32'd0);
        check("err_lo_state", {29'd0, dbg_state}, 32'd0);
        slot();
        check("err_lo_clear", {31'd0, ERR}, 32'd0);
        pulse_start({5'd20, 5'd0});
        check("err_hi_pulse", {31'd0, ERR}, 32'd1);
        check("err_hi_busy", {31'd0, BUSY}, 32'd0);
        slot();

        // HOLD at count 7 of target 10
        b0 = en0_cnt;
        pulse_start({5'd0, 5'd10});
        wait_cnt("hold_reach", {5'd0, 5'd7}, BOUND);
        HOLD = 1'b1;
        b1 = en0_cnt;
        repeat (6) slot();
        check("hold_cnt", {22'd0, stg}, {22'd0, 5'd0, 5'd7});
        check("hold_state", {29'd0, dbg_state}, 32'd3);
        check("hold_no_en", en0_cnt - b1, 32'd0);
        HOLD = 1'b0;
        wait_done("hold_done", BOUND);
        check("hold_final", {22'd0, stg}, {22'd0, 5'd0, 5'd10});
        check("hold_en0", en0_cnt - b0, 32'd10);
        ack_done("hold_ack");

        // ABORT in the match cycle
        pulse_start({5'd0, 5'd5});
        bd = done_cnt;
        wait_cnt("abort_reach", {5'd0, 5'd5}, BOUND);
        check("abort_in_run", {29'd0, dbg_state}, 32'd2);
        ABORT = 1'b1;
        slot();
        ABORT = 1'b0;
        check("abort_state", {29'd0, dbg_state}, 32'd0);
        check("abort_busy", {31'd0, BUSY}, 32'd0);
        repeat (3) slot();
        check("abort_no_done", done_cnt - bd, 32'd0);
        check("abort_cnt", {22'd0, stg}, {22'd0, 5'd0, 5'd5});

        // START while running is ignored; START in DONE restarts
        pulse_start({5'd0, 5'd8});
        wait_cnt("ign_reach", {5'd0, 5'd3}, BOUND);
        TGT   = {5'd0, 5'd2};
        START = 1'b1;
        slot();
        START = 1'b0;
        check("ign_state", {29'd0, dbg_state}, 32'd2);
        check("ign_err", {31'd0, ERR}, 32'd0);
        wait_done("ign_done", BOUND);
        check("ign_target", {22'd0, stg}, {22'd0, 5'd0, 5'd8});
        pulse_start({5'd0, 5'd2});
        check("restart_state", {29'd0, dbg_state}, 32'd1);
        check("restart_done_drop", {31'd0, DONE}, 32'd0);
        check("restart_clr", {31'd0, CLR_STG}, 32'd0);
        slot();
        wait_done("restart_done", BOUND);
        check("restart_cnt", {22'd0, stg}, {22'd0, 5'd0, 5'd2});
        ack_done("restart_ack");

        // Asynchronous reset mid-run
        pulse_start({5'd1, 5'd10});
        wait_cnt("arst_reach", {5'd0, 5'd5}, BOUND);
        #2;
        RST = 1'b0;
        #1;
        check("arst_en", {30'd0, EN_STG}, 32'd0);
        check("arst_busy", {31'd0, BUSY}, 32'd0);
        check("arst_done", {31'd0, DONE}, 32'd0);
        check("arst_clr", {31'd0, CLR_STG}, 32'd1);
        slot();
        RST = 1'b1;
        slot();
        check("arst_state", {29'd0, dbg_state}, 32'd0);
        check("arst_keep", {22'd0, stg}, {22'd0, 5'd0, 5'd5});

`ifdef COUNTER_CASCADE_CTRL_PRESCALE_EN
        // Internal tick every 4th RUN cycle, TICK ignored
        TICK = 1'b0;
        pulse_start({5'd0, 5'd3});
        slot();
        for (int r = 1; r <= 13; r++) begin
            check($sformatf("ps_en_c%0d", r), {31'd0, EN_STG[0]}, {31'd0, (r % 4) == 0});
            slot();
        end
        check("ps_done", {31'd0, DONE}, 32'd1);
        check("ps_cnt", {22'd0, stg}, {22'd0, 5'd0, 5'd3});
        ack_done("ps_ack");
`endif

        check("carry_order", carry_bad, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
